// File: rtl/reg_file_sb_if.sv
// Decode/execute-facing bus of the scoreboarded register file.
// The master side is the pipeline; the slave side is reg_file_sb.
interface reg_file_sb_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned RPORTS  = 4,
  parameter int unsigned FWD_SRC = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic                      FLUSH;
  logic                      STALL;
  logic                      MEM_WAIT;
  logic                      READY;
  logic [RPORTS*AW-1:0]      RADDR;
  logic [RPORTS-1:0]         RVALID;
  logic [RPORTS*XLEN-1:0]    RDATA;
  logic                      ISSUE_EN;
  logic [AW-1:0]             ISSUE_ADDR;
  logic                      ISSUE_READY;
  logic [FWD_SRC-1:0]        FWD_EN;
  logic [FWD_SRC*AW-1:0]     FWD_ADDR;
  logic [FWD_SRC*XLEN-1:0]   FWD_DATA;
  logic                      WEN;
  logic [AW-1:0]             WADDR;
  logic [XLEN-1:0]           WDATA;

  modport master (
    output FLUSH, STALL, MEM_WAIT, RADDR, ISSUE_EN, ISSUE_ADDR,
           FWD_EN, FWD_ADDR, FWD_DATA, WEN, WADDR, WDATA,
    input  READY, RVALID, RDATA, ISSUE_READY
  );

  modport slave (
    input  FLUSH, STALL, MEM_WAIT, RADDR, ISSUE_EN, ISSUE_ADDR,
           FWD_EN, FWD_ADDR, FWD_DATA, WEN, WADDR, WDATA,
    output READY, RVALID, RDATA, ISSUE_READY
  );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with per-register outstanding-write counters and forwarding.
// Optional feature: define REGFILE_INIT_EN to zero the array after reset (READY low meanwhile).
module reg_file_sb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned RPORTS  = 4,
  parameter int unsigned FWD_SRC = 2,
  parameter int unsigned CNT_W   = 2
) (
  input  logic          CLK,
  input  logic          RST,
  reg_file_sb_if.slave  bus
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [RPORTS*AW-1:0]   raddr_q, raddr_d;
  logic [CNT_W-1:0]       cnt_q [NREGS];
  logic [CNT_W-1:0]       cnt_d [NREGS];
  logic [XLEN-1:0]        mem_q [NREGS];

  logic                   ready_c;
  logic                   init_we_c;
  logic [AW-1:0]          init_idx_c;
  logic                   wen_c;
  logic                   issue_ready_c;
  logic                   issue_acc_c;
  logic [RPORTS-1:0]      rvalid_c;
  logic [RPORTS*XLEN-1:0] rdata_c;
  logic [AW-1:0]          a_c;
  logic                   hit_c;

`ifdef REGFILE_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  // Walk idx over x1..x(NREGS-1) writing zero, then open for business.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (RST) begin
      state_d = ST_INIT;
      idx_d   = AW'(1);
    end else if (state_q == ST_INIT) begin
      if (idx_q == AW'(NREGS - 1)) state_d = ST_RUN;
      else                         idx_d   = idx_q + AW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    state_q <= state_d;
    idx_q   <= idx_d;
  end

  assign ready_c    = (state_q == ST_RUN);
  assign init_we_c  = (state_q == ST_INIT) & ~RST;
  assign init_idx_c = idx_q;
`else
  assign ready_c    = 1'b1;
  assign init_we_c  = 1'b0;
  assign init_idx_c = '0;
`endif

  assign wen_c         = bus.WEN & (bus.WADDR != '0);
  assign issue_ready_c = (cnt_q[bus.ISSUE_ADDR] != CNT_MAX) & ready_c;
  assign issue_acc_c   = bus.ISSUE_EN & issue_ready_c & ~bus.STALL & ~bus.MEM_WAIT
                       & (bus.ISSUE_ADDR != '0);

  // Read-address capture: flush clears, freeze holds.
  always_comb begin
    raddr_d = bus.RADDR;
    if (RST || bus.FLUSH)             raddr_d = '0;
    else if (bus.MEM_WAIT || bus.STALL) raddr_d = raddr_q;
  end

  // Outstanding-write counters; issue and retire on the same register cancel.
  always_comb begin
    for (int r = 0; r < int'(NREGS); r++) cnt_d[r] = cnt_q[r];
    for (int r = 1; r < int'(NREGS); r++) begin
      if (RST || bus.FLUSH) begin
        cnt_d[r] = '0;
      end else if (issue_acc_c && (bus.ISSUE_ADDR == AW'(r))) begin
        if (!(wen_c && (bus.WADDR == AW'(r)))) cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (wen_c && (bus.WADDR == AW'(r)) && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge CLK) begin
    raddr_q <= raddr_d;
    for (int r = 0; r < int'(NREGS); r++) cnt_q[r] <= cnt_d[r];
  end

  // Array is not reset; the init walker's zero write wins a same-index collision.
  always_ff @(posedge CLK) begin
    if (wen_c && !(init_we_c && (bus.WADDR == init_idx_c))) mem_q[bus.WADDR] <= bus.WDATA;
    if (init_we_c) mem_q[init_idx_c] <= '0;
  end

  // Per read port: x0, then forwarding (lowest source wins), then retire bypass, then array.
  always_comb begin
    rvalid_c = '0;
    rdata_c  = '0;
    a_c      = '0;
    hit_c    = 1'b0;
    for (int p = 0; p < int'(RPORTS); p++) begin
      a_c   = raddr_q[p*AW +: AW];
      hit_c = 1'b0;
      if (a_c == '0) begin
        rvalid_c[p] = 1'b1;
        rdata_c[p*XLEN +: XLEN] = '0;
      end else begin
        for (int i = int'(FWD_SRC) - 1; i >= 0; i--) begin
          if (bus.FWD_ADDR[i*AW +: AW] == a_c) begin
            hit_c       = 1'b1;
            rvalid_c[p] = bus.FWD_EN[i];
            rdata_c[p*XLEN +: XLEN] = bus.FWD_DATA[i*XLEN +: XLEN];
          end
        end
        if (!hit_c) begin
          if (wen_c && (bus.WADDR == a_c)) begin
            rvalid_c[p] = (cnt_q[a_c] <= CNT_W'(1));
            rdata_c[p*XLEN +: XLEN] = bus.WDATA;
          end else begin
            rvalid_c[p] = (cnt_q[a_c] == '0);
            rdata_c[p*XLEN +: XLEN] = mem_q[a_c];
          end
        end
      end
      if (!ready_c) rvalid_c[p] = 1'b0;
    end
  end

  assign bus.READY       = ready_c;
  assign bus.ISSUE_READY = issue_ready_c;
  assign bus.RVALID      = rvalid_c;
  assign bus.RDATA       = rdata_c;
endmodule
